// File: rtl/cpu_wb_queue.sv
// rtl/cpu_wb_queue.sv - in-order write-back queue between memory access and register file
//
// Ports:
//   clk_i, reset_i              clock, asynchronous active-high reset
//   in_valid_i / in_ready_o     retiring-instruction handshake from the MA stage
//   pc_i, ir_i, load_i          instruction identity; rd = ir_i[11:7]
//   ma_size_i, byte_off_i       load access size and byte offset
//   wb_data_i, wb_valid_i       result for non-loads, rd write intent
//   dmem_rsp_valid_i/_data_i    in-order load responses (raw memory word)
//   wb_valid_o/_addr_o/_data_o  registered register-file write port
//   wb_pc_o                     pc of retired entry, NOP_PC when idle
//   pending_mask_o              registers with a queued write (bit 0 always 0)
//   count_o, empty_o            occupancy
//   rsp_err_o                   sticky flag: response arrived with no load outstanding
module cpu_wb_queue #(
    parameter int          DEPTH  = 4,
    parameter int          CNT_W  = $clog2(DEPTH) + 1,
    parameter logic [31:0] NOP_PC = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      ir_i,
    input  logic             load_i,
    input  logic [2:0]       ma_size_i,
    input  logic [1:0]       byte_off_i,
    input  logic [31:0]      wb_data_i,
    input  logic             wb_valid_i,
    input  logic             dmem_rsp_valid_i,
    input  logic [31:0]      dmem_rsp_data_i,
    output logic             wb_valid_o,
    output logic [4:0]       wb_addr_o,
    output logic [31:0]      wb_data_o,
    output logic [31:0]      wb_pc_o,
    output logic [31:0]      pending_mask_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             rsp_err_o
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic [31:0] pc_q   [DEPTH];
    logic [4:0]  rd_q   [DEPTH];
    logic [2:0]  size_q [DEPTH];
    logic [1:0]  off_q  [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [DEPTH-1:0] load_q;
    logic [DEPTH-1:0] wbv_q;
    logic [DEPTH-1:0] done_q;

    logic [PTR_W-1:0] head_q, tail_q, lptr_q;
    logic [CNT_W-1:0] count_q, ld_cnt_q;

    logic             enq, enq_load, rsp_fire, retire;
    logic [CNT_W-1:0] ld_rem;
    logic [DEPTH-1:0] live;
    logic [PTR_W-1:0] rel, idx, nxt_ld;
    logic             nxt_found;
    logic [4:0]       in_rd;
    logic             unused_ir;

    assign in_rd     = ir_i[11:7];
    assign unused_ir = ^{ir_i[31:12], ir_i[6:0]};

    assign in_ready_o = count_q < DEPTH_C;
    assign count_o    = count_q;
    assign empty_o    = count_q == '0;

    assign enq      = in_valid_i && in_ready_o;
    assign enq_load = enq && load_i;
    // Only loads already counted at the start of the cycle can take a response.
    assign rsp_fire = dmem_rsp_valid_i && (ld_cnt_q != '0);
    // done_q is registered, so a response completing the head retires next cycle.
    assign retire   = (count_q != '0) && done_q[head_q];
    assign ld_rem   = ld_cnt_q - CNT_W'(rsp_fire);

    function automatic logic [31:0] fmt_load(input logic [31:0] raw,
                                             input logic [2:0]  size,
                                             input logic [1:0]  off);
        logic [31:0] s;
        s = raw >> {off, 3'b000};
        case (size)
            SZ_B:    fmt_load = {{24{s[7]}}, s[7:0]};
            SZ_H:    fmt_load = {{16{s[15]}}, s[15:0]};
            SZ_BU:   fmt_load = {24'h0, s[7:0]};
            SZ_HU:   fmt_load = {16'h0, s[15:0]};
            default: fmt_load = s;
        endcase
    endfunction

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        live = '0;
        rel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel     = PTR_W'(i) - head_q;
            live[i] = CNT_W'(rel) < count_q;
        end
    end

    // Next outstanding load after the one being completed; loads complete in
    // issue order so the first incomplete load past lptr is the next one.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ld    = tail_q;
        idx       = '0;
        for (int k = 1; k < DEPTH; k++) begin
            idx = lptr_q + PTR_W'(k);
            if (!nxt_found && live[idx] && load_q[idx] && !done_q[idx]) begin
                nxt_found = 1'b1;
                nxt_ld    = idx;
            end
        end
    end

    always_comb begin
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && wbv_q[i]) pending_mask_o[rd_q[i]] = 1'b1;
        end
        pending_mask_o[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            lptr_q     <= '0;
            count_q    <= '0;
            ld_cnt_q   <= '0;
            done_q     <= '0;
            rsp_err_o  <= 1'b0;
            wb_valid_o <= 1'b0;
            wb_addr_o  <= '0;
            wb_data_o  <= '0;
            wb_pc_o    <= NOP_PC;
        end else begin
            if (dmem_rsp_valid_i && !rsp_fire) rsp_err_o <= 1'b1;
            if (rsp_fire) done_q[lptr_q] <= 1'b1;
            if (enq) begin
                done_q[tail_q] <= !load_i;
                tail_q         <= tail_q + 1'b1;
            end

            // With no load left outstanding, the newly enqueued load becomes the target.
            if (enq_load && ld_rem == '0) lptr_q <= tail_q;
            else if (rsp_fire)            lptr_q <= nxt_ld;
            ld_cnt_q <= ld_rem + CNT_W'(enq_load);

            count_q <= count_q + CNT_W'(enq) - CNT_W'(retire);

            if (retire) begin
                wb_valid_o <= wbv_q[head_q];
                wb_addr_o  <= rd_q[head_q];
                wb_data_o  <= data_q[head_q];
                wb_pc_o    <= pc_q[head_q];
                head_q     <= head_q + 1'b1;
            end else begin
                wb_valid_o <= 1'b0;
                wb_addr_o  <= '0;
                wb_data_o  <= '0;
                wb_pc_o    <= NOP_PC;
            end
        end
    end

    // Payload storage needs no reset: liveness is governed by the pointers.
    always_ff @(posedge clk_i) begin
        if (rsp_fire) data_q[lptr_q] <= fmt_load(dmem_rsp_data_i, size_q[lptr_q], off_q[lptr_q]);
        if (enq) begin
            pc_q[tail_q]   <= pc_i;
            rd_q[tail_q]   <= in_rd;
            size_q[tail_q] <= ma_size_i;
            off_q[tail_q]  <= byte_off_i;
            data_q[tail_q] <= wb_data_i;
            load_q[tail_q] <= load_i;
            wbv_q[tail_q]  <= wb_valid_i && (in_rd != 5'd0);
        end
    end
endmodule

// File: doc/cpu_wb_queue.md
# cpu_wb_queue

Parametrised in-order write-back stage for the pipelined Risc-V core. It sits between the memory-access stage and the register file. It accepts retiring instructions through a valid/ready handshake and buffers up to DEPTH of them. Load data returns from data memory with variable latency and is aligned and extended per access size. Completed entries drain to a registered write-back port in program order, one per cycle.

## Interface

- DEPTH, default 4: queue entries; power of two, 2..16.
- CNT_W, default $clog2(DEPTH)+1: width of the occupancy count.

Ports:

- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- in_valid_i  in  1  MA stage offers an instruction
- in_ready_o  out  1  queue can accept this cycle
- pc_i  in  32  program counter of offered instruction
- ir_i  in  32  instruction register; rd = ir_i[11:7]
- load_i  in  1  offered instruction is a load
- ma_size_i  in  3  access size: B=000, H=001, W=010, BU=100, HU=101
- byte_off_i  in  2  load byte offset within word
- wb_data_i  in  32  write-back data for non-loads
- wb_valid_i  in  1  instruction writes rd
- dmem_rsp_valid_i  in  1  load response present
- dmem_rsp_data_i  in  32  raw aligned memory word
- wb_valid_o  out  1  registered register-file write enable
- wb_addr_o  out  5  registered write address
- wb_data_o  out  32  registered write data
- wb_pc_o  out  32  pc of retired entry; NOP_PC when nothing retired
- pending_mask_o  out  32  bit r set while queued entry will write xr
- count_o  out  CNT_W  current occupancy
- empty_o  out  1  count_o == 0
- rsp_err_o  out  1  sticky: response with no outstanding load

## Operation

- Circular FIFO: head, tail and load pointers, each $clog2(DEPTH) bits. All pointers wrap modulo DEPTH.
- Each entry holds: pc, rd, load, size, off, wbv, data, done.
- wbv = wb_valid_i && rd != 0.
- in_ready_o = count < DEPTH. It does not depend on a same-cycle retire.
- Enqueue on in_valid_i && in_ready_o:
  - Non-loads store done=1 and data=wb_data_i.
  - Loads store done=0.
- Load pointer tracks the oldest load with done=0. Responses return strictly in load issue order.
- A response fills only an entry present at the start of the cycle. It never fills a load enqueued in the same cycle.
- Response data formatting:
  - s = dmem_rsp_data_i >> (8*off), zero-filled.
  - B: sign-extend s[7:0]. H: sign-extend s[15:0].
  - BU: zero-extend s[7:0]. HU: zero-extend s[15:0].
  - W: s.
  - The entry then sets done=1 and the load pointer advances to the next load with done=0.
- dmem_rsp_valid_i with no outstanding load sets rsp_err_o. The response is otherwise ignored. rsp_err_o clears only on reset.
- Retire when the queue is non-empty and head.done=1:
  - Register wb_valid_o=head.wbv, wb_addr_o=head.rd, wb_data_o=head.data, wb_pc_o=head.pc.
  - Advance head.
- No retire in a cycle: wb_valid_o=0, wb_addr_o=0, wb_data_o=0, wb_pc_o=NOP_PC.
- Enqueue and retire in the same cycle leave count unchanged.
- A response completing the head entry may not retire that entry in the same cycle. Retire the following cycle.
- pending_mask_o, combinational: OR over valid entries of (wbv ? 1<<rd : 0). Bit 0 is always 0.

## Timing

- Reset values (asynchronous): queue empty, pointers 0, count_o=0, empty_o=1, in_ready_o=1, wb_valid_o=0, wb_addr_o=0, wb_data_o=0, wb_pc_o=NOP_PC, pending_mask_o=0, rsp_err_o=0.
- Reset mid-operation discards all entries and outstanding loads. Responses arriving after reset deasserts with no load queued set rsp_err_o.
- Non-load accepted at edge k retires at edge k+1 if it is the head. Outputs are valid from k+1 until k+2.
- Load response at edge m retires at edge m+1 if the load is the head.
- An incomplete head blocks all younger completed entries. There is strictly no reordering.
- Throughput is one retire per cycle in steady state.
- A full queue drops in_ready_o the cycle after the DEPTH-th accept.
- in_ready_o and pending_mask_o are derived from registered state only. They are not combinational from inputs.

## Test plan

- Reset, then enqueue non-load pc=0x100, ir rd=5, data=0xDEADBEEF, wb_valid=1 → one cycle later wb_valid_o=1, wb_addr_o=5, wb_data_o=0xDEADBEEF, wb_pc_o=0x100; then empty_o=1.
- Load B, off=2 enqueued; response 0x00800000 three cycles later → wb_data_o=0xFFFFFF80 one cycle after the response. Repeat with BU → 0x00000080, HU off=2 with 0xABCD0000 → 0x0000ABCD.
- Enqueue load(rd=3), ALU(rd=4), ALU(rd=6) → no retire until the load response arrives; then rd 3, 4, 6 retire on consecutive cycles. pending_mask_o=0x58 while all three are queued.
- Enqueue DEPTH+2 entries back-to-back with the head load incomplete → in_ready_o=0 at count=DEPTH. It reasserts the cycle after the response-driven retire. count_o never exceeds DEPTH; pointers wrap correctly.
- wb_valid_i=1 with rd=0 → the entry retires with wb_valid_o=0, and pending_mask_o bit 0 stays 0.
- dmem_rsp_valid_i while the queue is empty → rsp_err_o=1 and stays set. Assert reset_i mid-load with 2 entries queued → all outputs return to reset values immediately.
